// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   op_t      : 3-bit command code carried from E-stage decode
//   OP_*      : command code values (7 is unused and acts as a no-op)
//   state_e   : sequencer state (IDLE waiting for a command, RUN counting latency)
//   is_muldiv : true for commands that occupy the unit for multiple cycles
package md_defs;

    typedef logic [2:0] op_t;

    localparam op_t OP_NONE  = 3'd0;
    localparam op_t OP_MULT  = 3'd1;
    localparam op_t OP_MULTU = 3'd2;
    localparam op_t OP_DIV   = 3'd3;
    localparam op_t OP_DIVU  = 3'd4;
    localparam op_t OP_MTHI  = 3'd5;
    localparam op_t OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_muldiv(op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Command/result bundle between the E stage and the mul/div sequencer.
//   start  : command valid
//   op     : command code, sampled with start
//   a, b   : rs / rt operands (forwarded values)
//   busy   : unit occupied (combinational, includes the issue cycle)
//   hi, lo : architectural HI/LO registers
// master = E stage / pause unit side, slave = sequencer.
interface muldiv_ctrl_if;
    import md_defs::*;

    logic        start;
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/muldiv_ctrl_arith.sv
// md_arith: purely combinational mul/div datapath.
//   op     : command code (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b   : 32-bit operands
//   result : {hi, lo} - 64-bit product, or {remainder, quotient}
// Signed division works on magnitudes and restores signs afterwards: the
// quotient truncates toward zero and the remainder takes the dividend's sign.
// This also makes 0x80000000 / -1 come out as 0x80000000 rem 0 with no
// special case. Divide by zero returns lo = all ones, hi = dividend.
module md_arith
    import md_defs::*;
(
    input  op_t         op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic        is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, b_div;
    logic [31:0] q_mag, r_mag, q_s, r_s;

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        result    = '0;
        is_signed = (op == OP_MULT) || (op == OP_DIV);

        // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
        // then correct for both signed and unsigned operands.
        a_ext = {{32{is_signed & a[31]}}, a};
        b_ext = {{32{is_signed & b[31]}}, b};
        prod  = a_ext * b_ext;

        a_mag = (is_signed && a[31]) ? -a : a;
        b_mag = (is_signed && b[31]) ? -b : b;
        // Keep the divider away from a zero divisor; that case is overridden below.
        b_div = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        q_s   = (is_signed && (a[31] ^ b[31])) ? -q_mag : q_mag;
        r_s   = (is_signed && a[31]) ? -r_mag : r_mag;

        case (op)
            OP_MULT, OP_MULTU: result = prod;
            OP_DIV, OP_DIVU:   result = (b == '0) ? {a, 32'hFFFF_FFFF} : {r_s, q_s};
            default:           result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multiply/divide sequencer owning the architectural HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; abandons any operation in flight
//   bus   : muldiv_ctrl_if slave (start/op/a/b in, busy/hi/lo out)
// A mul/div result is computed at issue and parked in phi/plo; cnt counts the
// modelled latency down and HI/LO are committed on the edge where cnt == 1.
// MTHI/MTLO write HI/LO directly from IDLE. Commands seen in RUN are ignored.
module muldiv_ctrl
    import md_defs::*;
#(
    parameter int MULT_LAT = 5,   // 1..255
    parameter int DIV_LAT  = 10   // 1..255
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_ctrl_if.slave   bus
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] result;

    md_arith u_arith (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .result (result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_muldiv(bus.op)) begin
                        phi_d   = result[63:32];
                        plo_d   = result[31:0];
                        cnt_d   = ((bus.op == OP_MULT) || (bus.op == OP_MULTU)) ?
                                  8'(MULT_LAT) : 8'(DIV_LAT);
                        state_d = ST_RUN;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every flop is cleared by reset; there is no memory array here to exempt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // busy rises in the issue cycle so the next instruction stalls at once;
    // the start-driven term is masked while reset is held low.
    assign bus.busy = (state_q == ST_RUN) ||
                      (reset && bus.start && is_muldiv(bus.op) && (state_q == ST_IDLE));
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases followed by random
// commands compared against a plain-arithmetic reference model.
module tb_muldiv_ctrl;
    import md_defs::*;

    localparam int ML = 5;
    localparam int DL = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    // Reference: {hi, lo} for a command, from 64-bit integer arithmetic.
    function automatic logic [63:0] model(op_t o, logic [31:0] av, logic [31:0] bv);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'b0, av} * {32'b0, bv};
            OP_DIV: begin
                if (bv == 0) return {av, 32'hFFFF_FFFF};
                q  = sa / sb;
                r  = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            OP_DIVU: begin
                if (bv == 0) return {av, 32'hFFFF_FFFF};
                return {av % bv, av / bv};
            end
            default: return 64'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_busy);
        check($sformatf("%s busy", tag), {31'b0, bus.busy}, {31'b0, exp_busy});
        check($sformatf("%s hi", tag), bus.hi, exp_hi);
        check($sformatf("%s lo", tag), bus.lo, exp_lo);
    endtask

    task automatic drive(input logic s, input op_t o, input logic [31:0] av, input logic [31:0] bv);
        bus.start = s;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
    endtask

    // Issue a mul/div in the current cycle and follow it to completion.
    // With intrude set, a MULT (cycle 2) and an MTLO (cycle 3) are presented
    // while the unit is busy; neither may have any effect.
    task automatic run_md(input op_t o, input logic [31:0] av, input logic [31:0] bv, input bit intrude);
        logic [63:0] r;
        int          lat;
        r   = model(o, av, bv);
        lat = (o == OP_MULT || o == OP_MULTU) ? ML : DL;
        drive(1'b1, o, av, bv);
        #1 check_state($sformatf("op%0d c0", o), 1'b1);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (intrude && c == 2)      drive(1'b1, OP_MULT, $urandom, $urandom);
            else if (intrude && c == 3) drive(1'b1, OP_MTLO, 32'h99, $urandom);
            else                        drive(1'b0, OP_NONE, $urandom, $urandom);
            #1 check_state($sformatf("op%0d c%0d", o, c), 1'b1);
        end
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        #1 check_state($sformatf("op%0d done", o), 1'b0);
    endtask

    // MTHI/MTLO in the current cycle; value checked in the next cycle.
    task automatic run_mt(input op_t o, input logic [31:0] av);
        drive(1'b1, o, av, $urandom);
        #1 check_state($sformatf("mt%0d c0", o), 1'b0);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        if (o == OP_MTHI) exp_hi = av;
        else              exp_lo = av;
        #1 check_state($sformatf("mt%0d c1", o), 1'b0);
    endtask

    initial begin
        op_t         rop;
        logic [31:0] ra, rb;

        // Reset state, including masking of the start-driven busy term.
        reset = 1'b0;
        drive(1'b1, OP_MULT, 32'd3, 32'd4);
        #1 check_state("reset", 1'b0);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        @(negedge clk);
        reset = 1'b1;
        #1 check_state("post reset", 1'b0);

        // Directed cases with literal expectations as well as the model.
        run_md(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("tp mult hi", bus.hi, 32'hFFFF_FFFF);
        check("tp mult lo", bus.lo, 32'hFFFF_FFFA);

        run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("tp div hi", bus.hi, 32'hFFFF_FFFF);
        check("tp div lo", bus.lo, 32'hFFFF_FFFD);

        run_md(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("tp divu hi", bus.hi, 32'd1);
        check("tp divu lo", bus.lo, 32'h7FFF_FFFC);

        run_md(OP_DIVU, 32'h1234, 32'd0, 1'b0);
        check("tp div0 hi", bus.hi, 32'h1234);
        check("tp div0 lo", bus.lo, 32'hFFFF_FFFF);

        run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("tp ovf hi", bus.hi, 32'd0);
        check("tp ovf lo", bus.lo, 32'h8000_0000);

        run_mt(OP_MTHI, 32'hAAAA);
        run_mt(OP_MTLO, 32'h5555);
        check("tp mt hi", bus.hi, 32'hAAAA);
        check("tp mt lo", bus.lo, 32'h5555);

        run_md(OP_MULTU, 32'h1_0000, 32'h1_0000, 1'b1);
        check("tp ign hi", bus.hi, 32'd1);
        check("tp ign lo", bus.lo, 32'd0);

        // Random commands, issued back to back with no bubble.
        for (int i = 0; i < 24; i++) begin
            rop = op_t'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (rop == OP_MTHI || rop == OP_MTLO) run_mt(rop, ra);
            else                                  run_md(rop, ra, rb, bit'($urandom_range(0, 1)));
        end

        // Reset in cycle 3 of a DIV: everything clears before the next edge.
        run_mt(OP_MTHI, 32'hDEAD_BEEF);
        run_mt(OP_MTLO, 32'hCAFE_F00D);
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        #1 check_state("rst div c0", 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive(1'b0, OP_NONE, '0, '0);
        end
        reset = 1'b0;
        drive(1'b1, OP_MULT, 32'd5, 32'd6);
        exp_hi = '0;
        exp_lo = '0;
        #1 check_state("rst mid", 1'b0);
        @(negedge clk);
        #1 check_state("rst held", 1'b0);
        reset = 1'b1;
        drive(1'b0, OP_NONE, '0, '0);
        #1 check_state("rst release", 1'b0);
        run_md(OP_MULT, 32'd12345, 32'd678, 1'b0);
        check("tp rst mult lo", bus.lo, 32'd8369910);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multiply/divide resource used by the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the E stage and models the unit's fixed multi-cycle latency. It owns the architectural HI/LO registers and drives a `busy` flag that the pause (stall) unit uses to hold MFHI/MFLO and further mul/div instructions in D.

## Interface
Parameters:
- `MULT_LAT`, default 5: cycles from MULT/MULTU issue to HI/LO commit; legal range 1 to 255.
- `DIV_LAT`, default 10: cycles from DIV/DIVU issue to HI/LO commit; legal range 1 to 255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  command valid, from E-stage decode.
- `op`  in  3  command code, sampled with `start`.
- `a`  in  32  rs operand, forwarded value.
- `b`  in  32  rt operand, forwarded value.
- `busy`  out  1  unit occupied; reset 0.
- `hi`  out  32  architectural HI; reset 0.
- `lo`  out  32  architectural LO; reset 0.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Codes 7 and NONE are no-ops.
- The block has two states, IDLE and RUN, plus an 8-bit down-counter `cnt` and 32-bit pending registers `phi`/`plo`.
- In IDLE with `start`:
  - MULT/MULTU/DIV/DIVU: latch the full result into `phi`/`plo`, load `cnt` with MULT_LAT or DIV_LAT, and go to RUN.
  - MTHI: write `hi` = `a` at this edge and stay in IDLE.
  - MTLO: write `lo` = `a` at this edge and stay in IDLE.
- In RUN, `cnt` decrements each cycle. At the edge where `cnt`==1, commit `hi`=`phi` and `lo`=`plo`, then go to IDLE.
- `start` while in RUN is ignored entirely: no state change, no HI/LO write. Preventing this is the pause unit's job; the bench checks that nothing changes.
- `busy` is combinational: (`start` && op in MULT..DIVU && state==IDLE) || state==RUN. It is asserted in the issue cycle so the following instruction stalls immediately.
- Arithmetic:
  - MULT: 64-bit signed product, {hi,lo}.
  - MULTU: 64-bit unsigned product, {hi,lo}.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=`a`.
- Reset asserted mid-operation: the operation is abandoned immediately and asynchronously, with state=IDLE, `cnt`=0, `hi`=`lo`=0, `busy`=0 (the `busy` term driven by `start` is masked while `reset` is low).

## Timing
- Issue at cycle 0, MULT: `busy`=1 in cycles 0 through MULT_LAT; new `hi`/`lo` visible and `busy`=0 from cycle MULT_LAT+1.
- DIV uses the same timing with DIV_LAT.
- MTHI/MTLO: the new value is visible in cycle 1, and `busy` stays 0 throughout.
- A new mul/div may issue in the first cycle after `busy` falls, with no bubble.
- `hi`/`lo` are registered outputs and never change while in RUN.

## Structure
- Shared package `md_defs`: the op-code constants, a 3-bit op typedef, and the state enum (IDLE, RUN).
- One sub-module, `md_arith`: purely combinational. It takes `op`, `a`, `b` and produces the 64-bit result, including the signed-division sign fixups and the divide-by-zero rule. The top module holds the FSM, counter and registers.

## Test plan
- MULT issue, a=0xFFFFFFFE (-2), b=3, MULT_LAT=5: `busy` is high for cycles 0 to 5; from cycle 6, hi=0xFFFFFFFF and lo=0xFFFFFFFA.
- DIV with a=-7 (0xFFFFFFF9), b=2: after DIV_LAT+1 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same operands: lo=0x7FFFFFFC, hi=1.
- DIVU with b=0, a=0x1234: lo=0xFFFFFFFF, hi=0x1234. Separately, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI 0xAAAA, then MTLO 0x5555 on consecutive cycles: hi=0xAAAA from cycle 1, lo=0x5555 from cycle 2, and `busy` never rises.
- MULTU 0x10000 × 0x10000, with a second MULT and an MTLO (a=0x99) presented in cycle 2: only the first command takes effect, giving hi=1, lo=0 at cycle MULT_LAT+1.
- Reset pulled low in cycle 3 of a DIV: `busy`, `hi` and `lo` drop to 0 before the next edge. After release, a fresh MULT completes with the normal latency.
